// File: rtl/ppu_vga_scanout.sv
// ppu_vga_scanout
//
// Read side of the VGA frame memory. Generates 640x480@60 timing from a single
// pixel clock, fetches every NES pixel from the vga_mem read port and drives
// sync, data-enable and 8-bit pixel outputs. The 256x240 NES picture is doubled
// to 512x480 and placed H_OFFSET columns from the left edge. The vblank window
// and a vblank-start pulse are provided for the PPU control logic.
//
// Optional feature macro: SCANOUT_BORDER_EN
//   defined   : visible pixels outside the picture show border_color
//   undefined : those pixels show 0x00 and border_color is ignored
//
// Parameters
//   H_OFFSET     first visible column of the scaled picture (default 64)
//   MEM_LATENCY  read latency of vga_mem in enabled cycles; only 1 is implemented
//
// Ports
//   clk           pixel clock
//   rst           asynchronous reset, active low
//   en            pixel enable; every register holds while low
//   vga_row       frame-memory read row (0..239), combinational from the counters
//   vga_col       frame-memory read column (0..255), combinational from the counters
//   vga_data      read data, valid one enabled cycle after the address
//   border_color  colour of visible non-picture pixels (SCANOUT_BORDER_EN only)
//   pix_data      pixel colour index
//   hsync_n       horizontal sync, active low
//   vsync_n       vertical sync, active low
//   de            high on the 640x480 visible region
//   vblank        high on lines 480..524
//   vblank_start  one-enabled-cycle pulse at the first pixel of line 480
//
// All outputs except the read address trail the counters by two enabled cycles,
// so sync, de, vblank and pix_data stay mutually aligned.

module ppu_vga_scanout #(
   parameter int H_OFFSET    = 64,
   parameter int MEM_LATENCY = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       en,
   output logic [9:0] vga_row,
   output logic [9:0] vga_col,
   input  logic [7:0] vga_data,
   input  logic [7:0] border_color,
   output logic [7:0] pix_data,
   output logic       hsync_n,
   output logic       vsync_n,
   output logic       de,
   output logic       vblank,
   output logic       vblank_start
);

   // Horizontal timing (pixels)
   localparam logic [9:0] H_VISIBLE    = 10'd640;
   localparam logic [9:0] H_SYNC_START = 10'd656;
   localparam logic [9:0] H_SYNC_END   = 10'd752;  // exclusive
   localparam logic [9:0] H_LAST       = 10'd799;

   // Vertical timing (lines)
   localparam logic [9:0] V_VISIBLE    = 10'd480;
   localparam logic [9:0] V_SYNC_START = 10'd490;
   localparam logic [9:0] V_SYNC_END   = 10'd492;  // exclusive
   localparam logic [9:0] V_LAST       = 10'd524;

   localparam logic [9:0]  H_OFF     = 10'(H_OFFSET);
   localparam logic [10:0] PIC_WIDTH = 11'd512;

   // Flags describing one counter position, carried through stage 1.
   typedef struct packed {
      logic pic;
      logic vis;
      logic hsync;
      logic vsync;
      logic vblank;
      logic vbstart;
   } pos_flags_t;

   logic [9:0] hcnt_q, hcnt_d;
   logic [9:0] vcnt_q, vcnt_d;
   logic [9:0] hrel;
   pos_flags_t cur_flags;
   pos_flags_t s1_q;

   logic [7:0] pix_q, pix_d;
   logic       hsync_n_q, vsync_n_q, de_q, vblank_q, vblank_start_q;
   logic [7:0] border_pix;

   // Only a one-cycle memory is supported; the parameter is kept so the
   // instantiation matches the loader side.
   logic unused_mem_latency;
   assign unused_mem_latency = (MEM_LATENCY == 1);

`ifdef SCANOUT_BORDER_EN
   assign border_pix = border_color;
`else
   logic unused_border;
   assign unused_border = ^border_color;
   assign border_pix    = 8'h00;
`endif

   // ---------------------------------------------------------------------
   // Raster counters
   // ---------------------------------------------------------------------
   always_comb begin
      // NOTE: every always_comb output is given a default first so no path
      // leaves it unassigned, which would otherwise infer a latch.
      hcnt_d = hcnt_q;
      vcnt_d = vcnt_q;
      if (en) begin
         if (hcnt_q == H_LAST) begin
            hcnt_d = '0;
            vcnt_d = (vcnt_q == V_LAST) ? '0 : vcnt_q + 10'd1;
         end else begin
            hcnt_d = hcnt_q + 10'd1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      // NOTE: state registers use non-blocking assignments so every flop
      // samples the pre-edge values regardless of process ordering.
      if (!rst) begin
         hcnt_q <= '0;
         vcnt_q <= '0;
      end else begin
         hcnt_q <= hcnt_d;
         vcnt_q <= vcnt_d;
      end
   end

   // ---------------------------------------------------------------------
   // Position decode and read address
   // ---------------------------------------------------------------------
   // The upper bound is compared in 11 bits so offsets near the top of the
   // 10-bit range cannot wrap the window end.
   assign hrel = hcnt_q - H_OFF;

   always_comb begin
      cur_flags         = '0;
      cur_flags.vis     = (hcnt_q < H_VISIBLE) && (vcnt_q < V_VISIBLE);
      cur_flags.pic     = (vcnt_q < V_VISIBLE) && (hcnt_q >= H_OFF) &&
                          ({1'b0, hcnt_q} < ({1'b0, H_OFF} + PIC_WIDTH));
      cur_flags.hsync   = (hcnt_q >= H_SYNC_START) && (hcnt_q < H_SYNC_END);
      cur_flags.vsync   = (vcnt_q >= V_SYNC_START) && (vcnt_q < V_SYNC_END);
      cur_flags.vblank  = (vcnt_q >= V_VISIBLE);
      cur_flags.vbstart = (vcnt_q == V_VISIBLE) && (hcnt_q == '0);
   end

   // 2x scaling: each NES pixel is addressed on two columns of two lines.
   assign vga_row = cur_flags.pic ? (vcnt_q >> 1) : '0;
   assign vga_col = cur_flags.pic ? (hrel >> 1)   : '0;

   // ---------------------------------------------------------------------
   // Stage 1: flags travel alongside the memory read
   // ---------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         s1_q <= '0;
      end else if (en) begin
         s1_q <= cur_flags;
      end
   end

   // ---------------------------------------------------------------------
   // Stage 2: output registers; vga_data is valid here for the stage-1 address
   // ---------------------------------------------------------------------
   always_comb begin
      pix_d = 8'h00;
      if (s1_q.pic) begin
         pix_d = vga_data;
      end else if (s1_q.vis) begin
         pix_d = border_pix;
      end
   end

   // vblank_start is a plain enabled register, so a pulse caught by en going
   // low simply holds until the next enabled cycle clears it.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pix_q          <= 8'h00;
         hsync_n_q      <= 1'b1;
         vsync_n_q      <= 1'b1;
         de_q           <= 1'b0;
         vblank_q       <= 1'b0;
         vblank_start_q <= 1'b0;
      end else if (en) begin
         pix_q          <= pix_d;
         hsync_n_q      <= ~s1_q.hsync;
         vsync_n_q      <= ~s1_q.vsync;
         de_q           <= s1_q.vis;
         vblank_q       <= s1_q.vblank;
         vblank_start_q <= s1_q.vbstart;
      end
   end

   assign pix_data     = pix_q;
   assign hsync_n      = hsync_n_q;
   assign vsync_n      = vsync_n_q;
   assign de           = de_q;
   assign vblank       = vblank_q;
   assign vblank_start = vblank_start_q;

endmodule

// File: tb/tb_ppu_vga_scanout.sv
// Self-checking bench for ppu_vga_scanout. A byte array stands in for vga_mem
// (one enabled cycle of read latency). The expected outputs for every sample
// are derived from the raster position implied by the number of enabled clock
// edges since reset release.

module tb_ppu_vga_scanout;

   localparam int H_OFF = 64;
   localparam int FRAME = 800 * 525;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       en  = 1'b0;
   logic [9:0] vga_row, vga_col;
   logic [7:0] vga_data = 8'h00;
   logic [7:0] border_color = 8'h00;
   logic [7:0] pix_data;
   logic       hsync_n, vsync_n, de, vblank, vblank_start;

   logic [7:0] mem [0:61439];
   int unsigned k;      // enabled edges since reset release
   int checks = 0;
   int errors = 0;

   ppu_vga_scanout #(.H_OFFSET(H_OFF), .MEM_LATENCY(1)) dut (
      .clk         (clk),
      .rst         (rst),
      .en          (en),
      .vga_row     (vga_row),
      .vga_col     (vga_col),
      .vga_data    (vga_data),
      .border_color(border_color),
      .pix_data    (pix_data),
      .hsync_n     (hsync_n),
      .vsync_n     (vsync_n),
      .de          (de),
      .vblank      (vblank),
      .vblank_start(vblank_start)
   );

   always #5 clk = ~clk;

   always @(posedge clk or negedge rst) begin
      if (!rst) k <= 0;
      else if (en) k <= k + 1;
   end

   // Frame memory with one enabled cycle of read latency.
   always @(posedge clk) begin
      if (en) vga_data <= mem[int'(vga_row) * 256 + int'(vga_col)];
   end

   localparam logic [12:0] RESET_OUT = {8'h00, 1'b1, 1'b1, 3'b000};

   function automatic logic [7:0] border_exp();
`ifdef SCANOUT_BORDER_EN
      return border_color;
`else
      return 8'h00;
`endif
   endfunction

   // {pix_data, hsync_n, vsync_n, de, vblank, vblank_start} after kk enabled edges
   function automatic logic [12:0] exp_out(int unsigned kk);
      int unsigned p, h, v;
      logic vis, pic;
      logic [7:0] pix;
      if (kk < 2) return RESET_OUT;
      p   = (kk - 2) % FRAME;
      h   = p % 800;
      v   = p / 800;
      vis = (h < 640) && (v < 480);
      pic = (v < 480) && (h >= H_OFF) && (h < H_OFF + 512);
      if (pic)      pix = mem[(v / 2) * 256 + (h - H_OFF) / 2];
      else if (vis) pix = border_exp();
      else          pix = 8'h00;
      return {pix, !(h >= 656 && h < 752), !(v >= 490 && v < 492), vis,
              (v >= 480), (h == 0 && v == 480)};
   endfunction

   // {vga_row, vga_col} while the counters sit at position kk
   function automatic logic [19:0] exp_addr(int unsigned kk);
      int unsigned p, h, v;
      p = kk % FRAME;
      h = p % 800;
      v = p / 800;
      if (v < 480 && h >= H_OFF && h < H_OFF + 512)
         return {10'(v / 2), 10'((h - H_OFF) / 2)};
      return 20'd0;
   endfunction

   function automatic logic [12:0] got_out();
      return {pix_data, hsync_n, vsync_n, de, vblank, vblank_start};
   endfunction

   task automatic test_reset();
      rst = 1'b0;
      en  = 1'b0;
      repeat (10) begin
         @(negedge clk);
         checks++;
         if (got_out() !== RESET_OUT) begin
            errors++;
            $display("FAIL reset_out got=%h exp=%h", got_out(), RESET_OUT);
         end
         checks++;
         if ({vga_row, vga_col} !== 20'd0) begin
            errors++;
            $display("FAIL reset_addr got=%h exp=0", {vga_row, vga_col});
         end
      end
   endtask

   task automatic test_release();
      rst = 1'b1;
      en  = 1'b1;
      @(negedge clk);
      checks++;
      if (de !== 1'b0) begin
         errors++;
         $display("FAIL de_cycle1 got=%b exp=0", de);
      end
      @(negedge clk);
      checks++;
      if (de !== 1'b1) begin
         errors++;
         $display("FAIL de_cycle2 got=%b exp=1", de);
      end
   endtask

   // Called directly after test_release: samples positions 0..1599.
   task automatic test_line_timing();
      int de_hi [2];
      int hs_lo [2];
      int rise_k [2];
      int fall_k;
      logic prev_de, prev_hs;
      prev_de = 1'b0;
      prev_hs = 1'b1;
      fall_k  = -1;
      de_hi   = '{0, 0};
      hs_lo   = '{0, 0};
      rise_k  = '{-1, -1};
      for (int n = 0; n < 1600; n++) begin
         int line;
         line = n / 800;
         checks++;
         if (got_out() !== exp_out(k)) begin
            errors++;
            $display("FAIL line_out k=%0d got=%h exp=%h", k, got_out(), exp_out(k));
         end
         if (de) de_hi[line]++;
         if (!hsync_n) hs_lo[line]++;
         if (de && !prev_de) rise_k[line] = int'(k);
         if (!hsync_n && prev_hs && fall_k < 0) fall_k = int'(k);
         prev_de = de;
         prev_hs = hsync_n;
         @(negedge clk);
      end
      for (int i = 0; i < 2; i++) begin
         checks++;
         if (de_hi[i] != 640) begin
            errors++;
            $display("FAIL de_width line=%0d got=%0d exp=640", i, de_hi[i]);
         end
         checks++;
         if (hs_lo[i] != 96) begin
            errors++;
            $display("FAIL hsync_width line=%0d got=%0d exp=96", i, hs_lo[i]);
         end
      end
      checks++;
      if (fall_k - rise_k[0] != 656) begin
         errors++;
         $display("FAIL de_to_hsync got=%0d exp=656", fall_k - rise_k[0]);
      end
      checks++;
      if (rise_k[1] - rise_k[0] != 800) begin
         errors++;
         $display("FAIL line_period got=%0d exp=800", rise_k[1] - rise_k[0]);
      end
   endtask

   // Memory holds col ^ row, border_color is 0x2A; continues the same frame.
   task automatic test_pixel_mapping();
      int          hs   [8] = '{0, 63, 64, 65, 66, 575, 576, 639};
      logic [7:0]  pexp [8];
      int          ah   [6] = '{63, 64, 65, 66, 575, 576};
      logic [19:0] aexp [6] = '{20'd0, {10'd2, 10'd0}, {10'd2, 10'd0},
                                {10'd2, 10'd1}, {10'd2, 10'd255}, 20'd0};
      pexp = '{border_exp(), border_exp(), 8'h01, 8'h01, 8'h00, 8'hFE,
               border_exp(), border_exp()};
      for (int i = 0; i < 8; i++) begin
         int unsigned target;
         int guard;
         target = 2 + 3 * 800 + hs[i];
         guard  = 0;
         while (k < target && guard < 5000) begin
            @(negedge clk);
            guard++;
         end
         checks++;
         if (k != target || pix_data !== pexp[i]) begin
            errors++;
            $display("FAIL pix_v3 h=%0d k=%0d got=%h exp=%h", hs[i], k, pix_data, pexp[i]);
         end
      end
      for (int i = 0; i < 6; i++) begin
         int unsigned target;
         int guard;
         target = 5 * 800 + ah[i];
         guard  = 0;
         while (k < target && guard < 5000) begin
            @(negedge clk);
            guard++;
         end
         checks++;
         if (k != target || {vga_row, vga_col} !== aexp[i]) begin
            errors++;
            $display("FAIL addr_v5 h=%0d k=%0d got=%h exp=%h", ah[i], k,
                     {vga_row, vga_col}, aexp[i]);
         end
      end
   endtask

   // Random picture, random border, random enable gaps.
   task automatic test_random();
      rst = 1'b0;
      en  = 1'b0;
      for (int i = 0; i < 61440; i++) mem[i] = 8'($urandom);
      border_color = 8'($urandom);
      repeat (3) @(negedge clk);
      rst = 1'b1;
      for (int n = 0; n < 4000; n++) begin
         en = ($urandom_range(0, 3) != 0);
         @(negedge clk);
         checks++;
         if (got_out() !== exp_out(k)) begin
            errors++;
            $display("FAIL rand_out k=%0d got=%h exp=%h", k, got_out(), exp_out(k));
         end
         checks++;
         if ({vga_row, vga_col} !== exp_addr(k)) begin
            errors++;
            $display("FAIL rand_addr k=%0d got=%h exp=%h", k, {vga_row, vga_col}, exp_addr(k));
         end
      end
   endtask

   // en toggling 1:1: same sequence at half rate, nothing moves on idle cycles.
   task automatic test_stall();
      logic [12:0] prev;
      logic        prev_en;
      rst = 1'b0;
      en  = 1'b0;
      repeat (2) @(negedge clk);
      rst     = 1'b1;
      prev    = got_out();
      prev_en = 1'b1;
      for (int n = 0; n < 3400; n++) begin
         en = n[0];
         @(negedge clk);
         checks++;
         if (got_out() !== exp_out(k)) begin
            errors++;
            $display("FAIL stall_out k=%0d got=%h exp=%h", k, got_out(), exp_out(k));
         end
         if (!en) begin
            checks++;
            if (got_out() !== prev) begin
               errors++;
               $display("FAIL stall_hold k=%0d got=%h exp=%h", k, got_out(), prev);
            end
         end
         prev    = got_out();
         prev_en = en;
      end
      checks++;
      if (k != 1700) begin
         errors++;
         $display("FAIL stall_rate got=%0d exp=1700", k);
      end
   endtask

   // Asynchronous reset in the middle of line 5, then a fresh frame.
   task automatic test_mid_frame_reset();
      int guard;
      en    = 1'b1;
      guard = 0;
      while (k < 5 * 800 + 300 && guard < 6000) begin
         @(negedge clk);
         guard++;
      end
      #2 rst = 1'b0;
      #1;
      checks++;
      if (got_out() !== RESET_OUT) begin
         errors++;
         $display("FAIL midreset_out got=%h exp=%h", got_out(), RESET_OUT);
      end
      checks++;
      if ({vga_row, vga_col} !== 20'd0) begin
         errors++;
         $display("FAIL midreset_addr got=%h exp=0", {vga_row, vga_col});
      end
      repeat (3) @(negedge clk);
      rst = 1'b1;
      for (int n = 0; n < 2000; n++) begin
         checks++;
         if (got_out() !== exp_out(k)) begin
            errors++;
            $display("FAIL restart_out k=%0d got=%h exp=%h", k, got_out(), exp_out(k));
         end
         checks++;
         if ({vga_row, vga_col} !== exp_addr(k)) begin
            errors++;
            $display("FAIL restart_addr k=%0d got=%h exp=%h", k, {vga_row, vga_col}, exp_addr(k));
         end
         @(negedge clk);
      end
   endtask

   initial begin
      for (int r = 0; r < 240; r++)
         for (int c = 0; c < 256; c++)
            mem[r * 256 + c] = 8'(c ^ r);
      border_color = 8'h2A;
      test_reset();
      test_release();
      test_line_timing();
      test_pixel_mapping();
      test_random();
      test_stall();
      test_mid_frame_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
